// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencing controller: stalls, bubbles, flushes, halt drain, stall counter
module pipe_ctrl #(
    parameter int MUL_LAT   = 3,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       rdReg1_ID,
    input  logic [3:0]       rdReg2_ID,
    input  logic             rdEn1_ID,
    input  logic             rdEn2_ID,
    input  logic [3:0]       wrReg_EX,
    input  logic             wrEn_EX,
    input  logic             memRd_EX,
    input  logic             mul_ID,
    input  logic             halt_ID,
    input  logic             br_taken_EX,
    input  logic             mem_busy,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             bubble_EX,
    output logic             bubble_MEM,
    output logic             bubble_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    // Counter widths sized to hold their largest load value.
    localparam int MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [MC_W-1:0] MUL_INIT   = MC_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [DC_W-1:0] DRAIN_INIT = DC_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MUL   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [MC_W-1:0] mul_cnt, mul_cnt_n;
    logic [DC_W-1:0] drain_cnt, drain_cnt_n;

    logic s_if, s_id, s_ex, s_mem, b_ex, b_mem, b_wb, f_ifid, f_idex, hlt;
    logic load_use;

    // A load in EX feeding an ID source cannot be forwarded in time; r0 is never a real dependency.
    assign load_use = memRd_EX & wrEn_EX & (wrReg_EX != 4'd0) &
                      ((rdEn1_ID & (rdReg1_ID == wrReg_EX)) |
                       (rdEn2_ID & (rdReg2_ID == wrReg_EX)));

    // State and occupancy counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            mul_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            mul_cnt   <= mul_cnt_n;
            drain_cnt <= drain_cnt_n;
        end
    end

    // Prioritised next-state and pipeline control; memory wait overrides everything and freezes state.
    always_comb begin
        state_n     = state;
        mul_cnt_n   = mul_cnt;
        drain_cnt_n = drain_cnt;
        s_if   = 1'b0;
        s_id   = 1'b0;
        s_ex   = 1'b0;
        s_mem  = 1'b0;
        b_ex   = 1'b0;
        b_mem  = 1'b0;
        b_wb   = 1'b0;
        f_ifid = 1'b0;
        f_idex = 1'b0;
        hlt    = 1'b0;
        if (mem_busy) begin
            s_if  = 1'b1;
            s_id  = 1'b1;
            s_ex  = 1'b1;
            s_mem = 1'b1;
            b_wb  = 1'b1;
        end else begin
            case (state)
                MUL: begin
                    s_if  = 1'b1;
                    s_id  = 1'b1;
                    s_ex  = 1'b1;
                    b_mem = 1'b1;
                    if (mul_cnt == '0) begin
                        state_n = RUN;
                    end else begin
                        mul_cnt_n = mul_cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    s_if = 1'b1;
                    s_id = 1'b1;
                    b_ex = 1'b1;
                    if (drain_cnt == '0) begin
                        state_n = HALT;
                    end else begin
                        drain_cnt_n = drain_cnt - 1'b1;
                    end
                end
                HALT: begin
                    s_if = 1'b1;
                    s_id = 1'b1;
                    b_ex = 1'b1;
                    hlt  = 1'b1;
                end
                default: begin
                    if (br_taken_EX) begin
                        // The ID instruction is squashed, so nothing it asks for is accepted.
                        f_ifid = 1'b1;
                        f_idex = 1'b1;
                    end else if (load_use) begin
                        s_if = 1'b1;
                        s_id = 1'b1;
                        b_ex = 1'b1;
                    end else if (halt_ID) begin
                        state_n     = DRAIN;
                        drain_cnt_n = DRAIN_INIT;
                    end else if (mul_ID && (MUL_LAT > 1)) begin
                        // The multiply's first EX cycle is its issue cycle, hence the -2 load.
                        state_n   = MUL;
                        mul_cnt_n = MUL_INIT;
                    end
                end
            endcase
        end
    end

    // All controls are forced low while reset is held, regardless of inputs.
    always_comb begin
        stall_IF    = rst_n & s_if;
        stall_ID    = rst_n & s_id;
        stall_EX    = rst_n & s_ex;
        stall_MEM   = rst_n & s_mem;
        bubble_EX   = rst_n & b_ex;
        bubble_MEM  = rst_n & b_mem;
        bubble_WB   = rst_n & b_wb;
        flush_IF_ID = rst_n & f_ifid;
        flush_ID_EX = rst_n & f_idex;
        halted      = rst_n & hlt;
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (s_if && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    // Output vector: {stall_IF,stall_ID,stall_EX,stall_MEM,bubble_EX,bubble_MEM,bubble_WB,flush_IF_ID,flush_ID_EX,halted}
    localparam logic [9:0] V_ZERO = 10'b0000000000;
    localparam logic [9:0] V_LU   = 10'b1100100000;
    localparam logic [9:0] V_MUL  = 10'b1110010000;
    localparam logic [9:0] V_BUSY = 10'b1111001000;
    localparam logic [9:0] V_FL   = 10'b0000000110;
    localparam logic [9:0] V_DR   = 10'b1100100000;
    localparam logic [9:0] V_HLT  = 10'b1100100001;

    logic       clk;
    logic       rst_n;
    logic [3:0] rdReg1_ID, rdReg2_ID, wrReg_EX;
    logic       rdEn1_ID, rdEn2_ID, wrEn_EX, memRd_EX, mul_ID, halt_ID, br_taken_EX, mem_busy;

    logic        stall_IF, stall_ID, stall_EX, stall_MEM, bubble_EX, bubble_MEM, bubble_WB;
    logic        flush_IF_ID, flush_ID_EX, halted;
    logic [15:0] stall_cnt;
    logic        stall_IF4, stall_ID4, stall_EX4, stall_MEM4, bubble_EX4, bubble_MEM4, bubble_WB4;
    logic        flush_IF_ID4, flush_ID_EX4, halted4;
    logic [3:0]  stall_cnt4;

    logic [9:0] vec, vec4;
    assign vec  = {stall_IF, stall_ID, stall_EX, stall_MEM, bubble_EX, bubble_MEM, bubble_WB,
                   flush_IF_ID, flush_ID_EX, halted};
    assign vec4 = {stall_IF4, stall_ID4, stall_EX4, stall_MEM4, bubble_EX4, bubble_MEM4, bubble_WB4,
                   flush_IF_ID4, flush_ID_EX4, halted4};

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rdReg1_ID(rdReg1_ID), .rdReg2_ID(rdReg2_ID), .rdEn1_ID(rdEn1_ID), .rdEn2_ID(rdEn2_ID),
        .wrReg_EX(wrReg_EX), .wrEn_EX(wrEn_EX), .memRd_EX(memRd_EX),
        .mul_ID(mul_ID), .halt_ID(halt_ID), .br_taken_EX(br_taken_EX), .mem_busy(mem_busy),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
        .bubble_EX(bubble_EX), .bubble_MEM(bubble_MEM), .bubble_WB(bubble_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .halted(halted),
        .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .rdReg1_ID(rdReg1_ID), .rdReg2_ID(rdReg2_ID), .rdEn1_ID(rdEn1_ID), .rdEn2_ID(rdEn2_ID),
        .wrReg_EX(wrReg_EX), .wrEn_EX(wrEn_EX), .memRd_EX(memRd_EX),
        .mul_ID(mul_ID), .halt_ID(halt_ID), .br_taken_EX(br_taken_EX), .mem_busy(mem_busy),
        .stall_IF(stall_IF4), .stall_ID(stall_ID4), .stall_EX(stall_EX4), .stall_MEM(stall_MEM4),
        .bubble_EX(bubble_EX4), .bubble_MEM(bubble_MEM4), .bubble_WB(bubble_WB4),
        .flush_IF_ID(flush_IF_ID4), .flush_ID_EX(flush_ID_EX4), .halted(halted4),
        .stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rdReg1_ID = 4'd0; rdReg2_ID = 4'd0; rdEn1_ID = 1'b0; rdEn2_ID = 1'b0;
        wrReg_EX = 4'd0; wrEn_EX = 1'b0; memRd_EX = 1'b0;
        mul_ID = 1'b0; halt_ID = 1'b0; br_taken_EX = 1'b0; mem_busy = 1'b0;
    endtask

    // Inputs are already driven (just after a rising edge); push the expectation,
    // compare at the falling edge, then advance the counter model at the rising edge.
    task automatic cyc(input string tag, input logic [9:0] e);
        logic [9:0] want;
        int sat4;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        sat4 = (exp_cnt > 15) ? 15 : exp_cnt;
        check({tag, "_out"},  32'(vec),        32'(want));
        check({tag, "_out4"}, 32'(vec4),       32'(want));
        check({tag, "_cnt"},  32'(stall_cnt),  32'(exp_cnt));
        check({tag, "_cnt4"}, 32'(stall_cnt4), 32'(sat4));
        @(posedge clk);
        if (rst_n && want[9]) exp_cnt++;
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        mem_busy = 1'b1;
        br_taken_EX = 1'b1;
        #2;
        check("rst_out",  32'(vec),       32'(V_ZERO));
        check("rst_out4", 32'(vec4),      32'(V_ZERO));
        check("rst_cnt",  32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        exp_cnt = 0;
        cyc("idle", V_ZERO);

        // Load-use on port 2, then the load has moved on
        memRd_EX = 1; wrEn_EX = 1; wrReg_EX = 4'd5; rdEn2_ID = 1; rdReg2_ID = 4'd5;
        cyc("lu_p2", V_LU);
        idle(); rdEn2_ID = 1; rdReg2_ID = 4'd5;
        cyc("lu_after", V_ZERO);
        idle(); memRd_EX = 1; wrEn_EX = 1; wrReg_EX = 4'd0;
        rdEn1_ID = 1; rdReg1_ID = 4'd0; rdEn2_ID = 1; rdReg2_ID = 4'd0;
        cyc("lu_r0", V_ZERO);
        idle(); memRd_EX = 1; wrEn_EX = 1; wrReg_EX = 4'd7; rdEn1_ID = 1; rdReg1_ID = 4'd7;
        cyc("lu_p1", V_LU);
        idle(); memRd_EX = 1; wrEn_EX = 1; wrReg_EX = 4'd7; rdReg1_ID = 4'd7;
        cyc("lu_noen", V_ZERO);
        idle(); wrEn_EX = 1; wrReg_EX = 4'd7; rdEn1_ID = 1; rdReg1_ID = 4'd7;
        cyc("alu_dep", V_ZERO);
        idle(); memRd_EX = 1; wrReg_EX = 4'd7; rdEn1_ID = 1; rdReg1_ID = 4'd7;
        cyc("lu_nowr", V_ZERO);

        // Multiply occupies EX for MUL_LAT cycles
        idle(); mul_ID = 1;
        cyc("mul_acc", V_ZERO);
        idle();
        cyc("mul1", V_MUL);
        cyc("mul2", V_MUL);
        cyc("mul_done", V_ZERO);

        // Branch wins over load-use and mul; flush deferred by mem_busy
        br_taken_EX = 1; memRd_EX = 1; wrEn_EX = 1; wrReg_EX = 4'd3;
        rdEn1_ID = 1; rdReg1_ID = 4'd3; mul_ID = 1;
        cyc("br_lu", V_FL);
        mem_busy = 1;
        cyc("br_busy0", V_BUSY);
        cyc("br_busy1", V_BUSY);
        mem_busy = 0;
        cyc("br_go", V_FL);
        idle();
        cyc("br_after", V_ZERO);

        // mem_busy inside a multiply extends it
        mul_ID = 1;
        cyc("mb_acc", V_ZERO);
        idle();
        cyc("mb_mul1", V_MUL);
        mem_busy = 1;
        repeat (4) cyc("mb_busy", V_BUSY);
        mem_busy = 0;
        cyc("mb_mul2", V_MUL);
        cyc("mb_done", V_ZERO);

        // Halt drain, then a sticky halt that ignores ID/EX requests
        halt_ID = 1;
        cyc("h_acc", V_ZERO);
        idle();
        repeat (3) cyc("drain", V_DR);
        mul_ID = 1; br_taken_EX = 1;
        repeat (3) cyc("halted", V_HLT);
        mem_busy = 1;
        cyc("h_busy", V_BUSY);
        mem_busy = 0;
        cyc("halted2", V_HLT);

        // Reset leaves HALT
        idle();
        rst_n = 1'b0;
        #1;
        check("hrst_out", 32'(vec), 32'(V_ZERO));
        check("hrst_cnt", 32'(stall_cnt), 32'd0);
        exp_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("post_rst", V_ZERO);

        // Asynchronous reset in the middle of DRAIN
        halt_ID = 1;
        cyc("h2_acc", V_ZERO);
        idle();
        cyc("drain_a", V_DR);
        mem_busy = 1;
        #2 rst_n = 1'b0;
        #1;
        check("drst_out",    32'(vec),       32'(V_ZERO));
        check("drst_halted", 32'(halted),    32'd0);
        check("drst_cnt",    32'(stall_cnt), 32'd0);
        exp_cnt = 0;
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        cyc("rst_run", V_ZERO);
        memRd_EX = 1; wrEn_EX = 1; wrReg_EX = 4'd9; rdEn2_ID = 1; rdReg2_ID = 4'd9;
        cyc("rst_lu", V_LU);
        idle();
        cyc("rst_idle", V_ZERO);

        // Counter saturation on the narrow instance
        mem_busy = 1;
        repeat (20) cyc("sat", V_BUSY);
        mem_busy = 0;
        cyc("sat_end", V_ZERO);
        cyc("sat_hold", V_ZERO);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
